// File: rtl/ray_pkg.sv
// Shared types for the ray/block intersection path: miss marker, pixel
// coordinate types, dispatcher FSM states and the FIFO payload layouts.
package ray_pkg;

  localparam logic [11:0] MISS_INDEX = 12'd256;

  typedef logic [10:0] pix_x_t;
  typedef logic [9:0]  pix_y_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dispatch_state_t;

  typedef struct packed {
    pix_x_t x;
    pix_y_t y;
  } coord_t;

  typedef struct packed {
    logic [11:0] block;
    logic [31:0] t;
  } rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with the head entry read straight from the register array,
// so data pushed on one edge is visible at the head on the next cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/pixel_ray_dispatcher.sv
// Rasters pixels into the intersection pipeline and re-pairs in-order results
// with their coordinates for the framebuffer. Optional: DISPATCH_STATS_EN.
module pixel_ray_dispatcher
  import ray_pkg::*;
#(
  parameter int H_RES        = 1024,
  parameter int V_RES        = 768,
  parameter int MAX_INFLIGHT = 64
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             start_in,
  output logic                             busy_out,
  output logic                             frame_done_out,
  output logic [10:0]                      req_x_out,
  output logic [9:0]                       req_y_out,
  output logic                             req_valid_out,
  input  logic                             rsp_valid_in,
  input  logic [11:0]                      rsp_block_in,
  input  logic [31:0]                      rsp_t_in,
  output logic [$clog2(H_RES*V_RES)-1:0]   fb_addr_out,
  output logic [11:0]                      fb_block_out,
  output logic [31:0]                      fb_t_out,
  output logic                             fb_hit_out,
  output logic                             fb_valid_out,
  input  logic                             fb_ready_in,
  output logic                             error_out,
  output logic [1:0]                       state_out
`ifdef DISPATCH_STATS_EN
  ,
  output logic [$clog2(H_RES*V_RES+1)-1:0] hit_count_out
`endif
);

  localparam int     ADDR_W = $clog2(H_RES*V_RES);
  localparam int     CNT_W  = $clog2(MAX_INFLIGHT+1);
  localparam pix_x_t X_LAST = pix_x_t'(H_RES-1);
  localparam pix_y_t Y_LAST = pix_y_t'(V_RES-1);

  dispatch_state_t state_q, state_d;
  pix_x_t          x_q;
  pix_y_t          y_q;
  logic [CNT_W-1:0] inflight_q, inflight_d, pending_q;
  logic            error_q;
  logic            issue, last_pix, start_ok, hs;
  logic            rsp_take, rsp_err, rsp_full, rsp_empty, coord_full, coord_empty;
  coord_t          coord_in, coord_head;
  rsp_t            rsp_in, rsp_head;

  assign start_ok = (state_q == ST_IDLE) && start_in;
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  // The pipeline cannot stall, so the credit check is the only issue gate.
  assign issue    = (state_q == ST_ISSUE) && (inflight_q < CNT_W'(MAX_INFLIGHT)) && !coord_full;

  // fb port: a write transfers on any cycle with fb_valid_out & fb_ready_in;
  // once raised, valid and all fields hold until that transfer.
  assign fb_valid_out = !rsp_empty;
  assign hs           = fb_valid_out && fb_ready_in;

  assign rsp_take   = rsp_valid_in && (pending_q != '0) && !rsp_full;
  assign rsp_err    = rsp_valid_in && ((pending_q == '0) || rsp_full);
  assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(hs);

  assign coord_in = '{x: x_q, y: y_q};
  assign rsp_in   = '{block: rsp_block_in, t: rsp_t_in};

  sync_fifo #(.WIDTH(21), .DEPTH(MAX_INFLIGHT)) u_coord_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (issue),
    .push_data (coord_in),
    .pop       (hs),
    .full      (coord_full),
    .empty     (coord_empty),
    .head      (coord_head)
  );

  sync_fifo #(.WIDTH(44), .DEPTH(MAX_INFLIGHT)) u_rsp_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (rsp_take),
    .push_data (rsp_in),
    .pop       (hs && !coord_empty),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .head      (rsp_head)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_in) state_d = ST_ISSUE;
      ST_ISSUE: if (issue && last_pix) state_d = ST_DRAIN;
      ST_DRAIN: if (inflight_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= '0;
      pending_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      pending_q  <= pending_q + CNT_W'(issue)
                    - CNT_W'(rsp_valid_in && (pending_q != '0));
      if (start_ok) begin
        x_q <= '0;
        y_q <= '0;
      end else if (issue) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + pix_y_t'(1);
        end else begin
          x_q <= x_q + pix_x_t'(1);
        end
      end
      if (rsp_err)       error_q <= 1'b1;
      else if (start_ok) error_q <= 1'b0;
    end
  end

  assign busy_out       = (state_q != ST_IDLE);
  assign frame_done_out = (state_q == ST_DONE);
  assign req_valid_out  = issue;
  assign req_x_out      = x_q;
  assign req_y_out      = y_q;
  assign error_out      = error_q;
  assign state_out      = state_q;

  assign fb_addr_out  = ADDR_W'(coord_head.y) * ADDR_W'(H_RES) + ADDR_W'(coord_head.x);
  assign fb_block_out = rsp_head.block;
  assign fb_t_out     = rsp_head.t;
  assign fb_hit_out   = fb_valid_out && (rsp_head.block != MISS_INDEX);

`ifdef DISPATCH_STATS_EN
  logic [$clog2(H_RES*V_RES+1)-1:0] hit_count_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)               hit_count_q <= '0;
    else if (start_ok)         hit_count_q <= '0;
    else if (hs && fb_hit_out) hit_count_q <= hit_count_q + 1'b1;
  end

  assign hit_count_out = hit_count_q;
`endif

endmodule

// File: tb/tb_pixel_ray_dispatcher.sv
// Directed bench for pixel_ray_dispatcher on a 4x2 frame with a 5-stage
// pipeline model; stats checks compile in with DISPATCH_STATS_EN.
module tb_pixel_ray_dispatcher;
  import ray_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int MI = 4;
  localparam int NPIX = H * V;
  localparam int LAT  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk = ~clk;

  logic        start_in = 1'b0;
  logic        fb_ready_in = 1'b1;
  logic        busy_out, frame_done_out, req_valid_out, fb_hit_out, fb_valid_out, error_out;
  logic [10:0] req_x_out;
  logic [9:0]  req_y_out;
  bit          rsp_valid_in;
  bit   [11:0] rsp_block_in;
  bit   [31:0] rsp_t_in;
  logic [2:0]  fb_addr_out;
  logic [11:0] fb_block_out;
  logic [31:0] fb_t_out;
  logic [1:0]  state_out;
`ifdef DISPATCH_STATS_EN
  logic [3:0]  hit_count_out;
`endif

  pixel_ray_dispatcher #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(MI)) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .req_x_out      (req_x_out),
    .req_y_out      (req_y_out),
    .req_valid_out  (req_valid_out),
    .rsp_valid_in   (rsp_valid_in),
    .rsp_block_in   (rsp_block_in),
    .rsp_t_in       (rsp_t_in),
    .fb_addr_out    (fb_addr_out),
    .fb_block_out   (fb_block_out),
    .fb_t_out       (fb_t_out),
    .fb_hit_out     (fb_hit_out),
    .fb_valid_out   (fb_valid_out),
    .fb_ready_in    (fb_ready_in),
    .error_out      (error_out),
    .state_out      (state_out)
`ifdef DISPATCH_STATS_EN
    ,
    .hit_count_out  (hit_count_out)
`endif
  );

  // ---------------- pipeline model and monitor (negedge) ----------------
  logic [7:0]  miss_mask = 8'h00;
  bit          pv [0:LAT-1];
  int          pidx [0:LAT-1];
  int          cyc, req_cnt, done_cnt, done_cyc, last_hs_cyc, fb_valid_cnt;
  logic [3:0]  hc_at_done;
  logic [2:0]  wr_addr_q[$];
  logic [11:0] wr_blk_q[$];
  logic        wr_hit_q[$];
  logic [31:0] wr_t_q[$];

  function automatic logic [11:0] blk_of(int p);
    if (miss_mask[p]) return MISS_INDEX;
    return 12'(p % 3);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (fb_valid_out) fb_valid_cnt++;
    if (fb_valid_out && fb_ready_in) begin
      wr_addr_q.push_back(fb_addr_out);
      wr_blk_q.push_back(fb_block_out);
      wr_hit_q.push_back(fb_hit_out);
      wr_t_q.push_back(fb_t_out);
      last_hs_cyc = cyc;
    end
    if (frame_done_out) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef DISPATCH_STATS_EN
      hc_at_done = hit_count_out;
`else
      hc_at_done = 4'd0;
`endif
    end
    if (req_valid_out) req_cnt++;
    rsp_valid_in = pv[LAT-1];
    rsp_block_in = blk_of(pidx[LAT-1]);
    rsp_t_in     = 32'h4000_0000 | 32'(pidx[LAT-1]);
    for (int i = LAT-1; i > 0; i--) begin
      pv[i]   = pv[i-1];
      pidx[i] = pidx[i-1];
    end
    pv[0]   = req_valid_out;
    pidx[0] = int'(req_y_out) * H + int'(req_x_out);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    step(1);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      step(1);
      k++;
    end
    chk("frame_done_timeout", 64'(done_cnt > d0), 64'd1);
  endtask

  // Expected entry: {hit, block, addr}.
  task automatic check_frame(input string name, input int w0);
    logic [15:0] e;
    for (int p = 0; p < NPIX; p++)
      exp_q.push_back({blk_of(p) != MISS_INDEX, blk_of(p), 3'(p)});
    chk({name, "_write_count"}, 64'(wr_addr_q.size() - w0), 64'(NPIX));
    for (int i = 0; i < NPIX; i++) begin
      e = exp_q.pop_front();
      if (w0 + i < wr_addr_q.size()) begin
        chk($sformatf("%s_addr%0d", name, i), 64'(wr_addr_q[w0+i]), 64'(e[2:0]));
        chk($sformatf("%s_blk%0d", name, i),  64'(wr_blk_q[w0+i]),  64'(e[14:3]));
        chk($sformatf("%s_hit%0d", name, i),  64'(wr_hit_q[w0+i]),  64'(e[15]));
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w0, r0, d0, f0, k;

    // Reset state
    step(3);
    chk("rst_busy",     64'(busy_out),       64'd0);
    chk("rst_done",     64'(frame_done_out), 64'd0);
    chk("rst_req",      64'(req_valid_out),  64'd0);
    chk("rst_fb_valid", 64'(fb_valid_out),   64'd0);
    chk("rst_addr",     64'(fb_addr_out),    64'd0);
    chk("rst_error",    64'(error_out),      64'd0);
    chk("rst_state",    64'(state_out),      64'(ST_IDLE));
    rst_in = 1'b1;
    step(2);

    // Baseline frame
    w0 = wr_addr_q.size(); r0 = req_cnt; d0 = done_cnt;
    pulse_start();
    chk("base_busy_after_start", 64'(busy_out), 64'd1);
    wait_done(d0);
    chk("base_busy_after_done", 64'(busy_out), 64'd0);
    chk("base_done_latency", 64'(done_cyc), 64'(last_hs_cyc + 1));
    chk("base_req_count", 64'(req_cnt - r0), 64'd8);
    chk("base_error", 64'(error_out), 64'd0);
    check_frame("base", w0);
    if (w0 + 2 < wr_t_q.size()) chk("base_t_passthru", 64'(wr_t_q[w0+2]), 64'h4000_0002);

    // Backpressure from the start
    fb_ready_in = 1'b0;
    w0 = wr_addr_q.size(); r0 = req_cnt; d0 = done_cnt;
    pulse_start();
    step(40);
    chk("bp_req_capped", 64'(req_cnt - r0), 64'd4);
    chk("bp_fb_valid", 64'(fb_valid_out), 64'd1);
    chk("bp_hold_addr", 64'(fb_addr_out), 64'd0);
    step(3);
    chk("bp_hold_addr_later", 64'(fb_addr_out), 64'd0);
    chk("bp_hold_blk_later", 64'(fb_block_out), 64'd0);
    fb_ready_in = 1'b1;
    wait_done(d0);
    chk("bp_req_total", 64'(req_cnt - r0), 64'd8);
    chk("bp_error", 64'(error_out), 64'd0);
    check_frame("bp", w0);

    // Misses at pixels 1 and 6
    miss_mask = 8'b0100_0010;
    w0 = wr_addr_q.size(); d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    check_frame("miss", w0);
    miss_mask = 8'h00;

    // start_in during DRAIN is ignored
    w0 = wr_addr_q.size(); r0 = req_cnt; d0 = done_cnt;
    pulse_start();
    k = 0;
    while (state_out != ST_DRAIN && k < 100) begin
      step(1);
      k++;
    end
    chk("ign_reached_drain", 64'(state_out), 64'(ST_DRAIN));
    pulse_start();
    wait_done(d0);
    step(20);
    chk("ign_req_count", 64'(req_cnt - r0), 64'd8);
    chk("ign_done_count", 64'(done_cnt - d0), 64'd1);
    chk("ign_busy", 64'(busy_out), 64'd0);
    check_frame("ign", w0);

    // Reset mid-frame after 3 issues
    w0 = wr_addr_q.size(); r0 = req_cnt;
    pulse_start();
    k = 0;
    while (req_cnt - r0 < 3 && k < 50) begin
      step(1);
      k++;
    end
    chk("mid_three_issued", 64'(req_cnt - r0), 64'd3);
    rst_in = 1'b0;
    #1;
    chk("mid_rst_req",      64'(req_valid_out), 64'd0);
    chk("mid_rst_busy",     64'(busy_out),      64'd0);
    chk("mid_rst_fb_valid", 64'(fb_valid_out),  64'd0);
    chk("mid_rst_addr",     64'(fb_addr_out),   64'd0);
    chk("mid_rst_state",    64'(state_out),     64'(ST_IDLE));
    step(2);
    rst_in = 1'b1;
    f0 = fb_valid_cnt;
    step(15);
    chk("mid_stale_error", 64'(error_out), 64'd1);
    chk("mid_no_fb_valid", 64'(fb_valid_cnt - f0), 64'd0);
    chk("mid_no_writes",   64'(wr_addr_q.size() - w0), 64'd0);
    w0 = wr_addr_q.size(); d0 = done_cnt;
    pulse_start();
    chk("mid_error_cleared", 64'(error_out), 64'd0);
    wait_done(d0);
    check_frame("recover", w0);

`ifdef DISPATCH_STATS_EN
    // Stats: pixels 0, 3 and 5 miss
    miss_mask = 8'b0010_1001;
    d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    chk("stats_hits_at_done", 64'(hc_at_done), 64'd5);
    chk("stats_hold", 64'(hit_count_out), 64'd5);
    miss_mask = 8'h00;
    d0 = done_cnt;
    pulse_start();
    chk("stats_cleared", 64'(hit_count_out), 64'd0);
    wait_done(d0);
    chk("stats_full_hits", 64'(hc_at_done), 64'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
